cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
Run-control sequencer for the 5-stage pipelined CPU. Produces the clock-enable `cpu_ce` that gates every pipeline register, including PC, IF/ID, ID/EX, EX/MEM, MEM/WB and register-file/data-memory writes. Accepts host/debug commands: halt, free-run, step N cycles, and set/clear one PC breakpoint. Sits between the debug front-end and the CPU; observes the CPU's IF-stage `pc`.

Parameters:
- STEP_W, 16, width of step count taken from cmd_arg[STEP_W-1:0].
- RESET_RUN, 0, state after reset: 0 = HALT, 1 = RUN.

Ports:
- cpu_clk, input, 1, clock.
- cpu_rstn, input, 1, reset.
- cmd_valid, input, 1, command offered.
- cmd_ready, output, 1, command can be accepted this cycle.
- cmd_op, input, 2, 00 HALT, 01 RUN, 10 STEP, 11 SET_BP.
- cmd_arg, input, 32, STEP: cycle count; SET_BP: address (bit0=1 means disable).
- pc, input, 32, current IF-stage PC from the CPU.
- cpu_ce, output, 1, pipeline clock enable.
- halted, output, 1, state==HALT.
- bp_hit, output, 1, sticky: last halt was caused by the breakpoint.
- state_o, output, 2, 00 HALT, 01 RUN, 10 STEP.
- cycle_cnt, output, 32, count of cycles with cpu_ce=1 (see Optional Feature).

Behaviour:
- Reset: cpu_rstn is asynchronous, active-low; the clock is cpu_clk.
  - state = HALT, or RUN if RESET_RUN=1.
  - bp_en=0, bp_addr=0, bp_hit=0, skip_bp=0, step_cnt=0, cycle_cnt=0.
  - Outputs follow from these values.
  - Reset mid-STEP or mid-RUN aborts immediately; no command is retained.
- Handshake: a command is accepted at a rising edge when cmd_valid && cmd_ready.
  - cmd_ready = 1 in HALT and RUN, 0 in STEP (a step is uninterruptible).
  - cmd_valid held while cmd_ready=0 is accepted at the first edge with cmd_ready=1.
- Command HALT:
  - From RUN: state becomes HALT after the accepting edge.
  - From HALT: no-op.
  - bp_hit unchanged.
- Command RUN:
  - From HALT: state becomes RUN; skip_bp=1; bp_hit=0.
  - From RUN: no-op.
- Command STEP (accepted in HALT or RUN):
  - step_cnt = cmd_arg[STEP_W-1:0]; a value of 0 is treated as 1.
  - state becomes STEP; bp_hit=0.
- Command SET_BP (any accepting state; state unchanged):
  - bp_addr = {cmd_arg[31:2], 2'b00}.
  - bp_en = ~cmd_arg[0].
- Breakpoint match (combinational): bp_match = bp_en && state==RUN && !skip_bp && pc==bp_addr.
- skip_bp: cleared at any edge where pc != bp_addr. This allows resuming from the breakpoint PC even across pipeline stalls.
- cpu_ce (combinational):
  - 1 when (state==RUN && !bp_match) or state==STEP.
  - 0 otherwise.
  - The instruction at bp_addr is therefore never fetched past IF. PC is frozen at bp_addr.
- On bp_match: state becomes HALT and bp_hit=1 at the same edge.
  - Simultaneous bp_match and an accepted command: the command wins, except HALT, which gives an identical result.
- STEP: cpu_ce=1 for exactly step_cnt consecutive cycles.
  - step_cnt decrements on each edge.
  - At the edge where step_cnt==1, state becomes HALT.
  - Breakpoints are ignored in STEP.
- Latency: a command accepted at edge k affects cpu_ce in cycle k+1. cpu_ce never depends combinationally on cmd_*.
- halted = (state==HALT); state_o encodes the current state.
- cmd_op value 11 with cmd_arg[0]=1 while bp_en=0 is a harmless no-op.

Optional Feature:
Macro RUN_CTRL_CYCLE_CNT_EN.
- Defined: cycle_cnt increments at each edge where cpu_ce=1, wraps 0xFFFFFFFF to 0, and clears only on reset.
- Undefined: the counter register is not built and cycle_cnt is tied to 32'h0.

Test Plan:
- Reset with RESET_RUN=0 → halted=1, cpu_ce=0, bp_hit=0, cycle_cnt=0. Hold 10 cycles; cycle_cnt stays 0.
- From HALT, STEP arg=3 → cpu_ce=1 for exactly 3 cycles starting the cycle after acceptance; cmd_ready=0 during those cycles; then halted=1 and cycle_cnt=3. STEP arg=0 gives 1 cycle.
- SET_BP 0x00000010, then RUN, with pc incrementing by 4 from 0 → cpu_ce drops in the cycle pc==0x10; next edge halted=1, bp_hit=1, pc held at 0x10.
- RUN again with pc held at 0x10 for 2 stall cycles → no re-trigger, and cpu_ce stays 1. After pc moves to 0x14 and later returns to 0x10, the breakpoint hits again.
- SET_BP arg 0x00000011 (disable), then RUN, with pc passing 0x10 → no halt. A HALT command then gives cpu_ce=0 from the following cycle, bp_hit=0.
- In RUN, assert cpu_rstn=0 mid-cycle → cpu_ce=0 and halted=1 immediately (asynchronous). bp_en=0 after release.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer: gates the CPU pipeline via cpu_ce (halt / run / step N / PC breakpoint).
// Define RUN_CTRL_CYCLE_CNT_EN to build the cpu_ce=1 cycle counter; otherwise cycle_cnt reads 0.
module cpu_run_ctrl #(
  parameter int unsigned STEP_W    = 16,
  parameter bit          RESET_RUN = 1'b0
) (
  input  logic        cpu_clk,
  input  logic        cpu_rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_arg,
  input  logic [31:0] pc,
  output logic        cpu_ce,
  output logic        halted,
  output logic        bp_hit,
  output logic [1:0]  state_o,
  output logic [31:0] cycle_cnt
);

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } state_e;

  localparam logic [1:0] OP_HALT = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;

  localparam state_e            RESET_STATE = RESET_RUN ? ST_RUN : ST_HALT;
  localparam logic [STEP_W-1:0] STEP_ONE    = STEP_W'(1);

  state_e              state_q,    state_d;
  logic                bp_en_q,    bp_en_d;
  logic [31:0]         bp_addr_q,  bp_addr_d;
  logic                bp_hit_q,   bp_hit_d;
  logic                skip_bp_q,  skip_bp_d;
  logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
  logic                bp_match;
  logic                cmd_accept;
  logic [STEP_W-1:0]   step_arg;

  assign cmd_accept = cmd_valid && cmd_ready;
  assign step_arg   = cmd_arg[STEP_W-1:0];

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q    <= RESET_STATE;
      bp_en_q    <= 1'b0;
      bp_addr_q  <= 32'h0;
      bp_hit_q   <= 1'b0;
      skip_bp_q  <= 1'b0;
      step_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      bp_en_q    <= bp_en_d;
      bp_addr_q  <= bp_addr_d;
      bp_hit_q   <= bp_hit_d;
      skip_bp_q  <= skip_bp_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bp_en_d    = bp_en_q;
    bp_addr_d  = bp_addr_q;
    bp_hit_d   = bp_hit_q;
    skip_bp_d  = skip_bp_q;
    step_cnt_d = step_cnt_q;

    // Skip stays armed while the CPU sits on the breakpoint PC (e.g. stalls after resume).
    if (pc != bp_addr_q) skip_bp_d = 1'b0;

    if (cmd_accept) begin
      case (cmd_op)
        OP_HALT: begin
          state_d = ST_HALT;
          if (bp_match) bp_hit_d = 1'b1;
        end
        OP_RUN: begin
          if (state_q == ST_HALT) begin
            state_d   = ST_RUN;
            skip_bp_d = 1'b1;
            bp_hit_d  = 1'b0;
          end
        end
        OP_STEP: begin
          state_d    = ST_STEP;
          step_cnt_d = (step_arg == '0) ? STEP_ONE : step_arg;
          bp_hit_d   = 1'b0;
        end
        default: begin
          bp_addr_d = {cmd_arg[31:2], 2'b00};
          bp_en_d   = ~cmd_arg[0];
        end
      endcase
    end else if (state_q == ST_STEP) begin
      step_cnt_d = step_cnt_q - STEP_ONE;
      if (step_cnt_q <= STEP_ONE) state_d = ST_HALT;
    end else if (bp_match) begin
      state_d  = ST_HALT;
      bp_hit_d = 1'b1;
    end
  end

  always_comb begin
    cmd_ready = (state_q != ST_STEP);
    bp_match  = bp_en_q && (state_q == ST_RUN) && !skip_bp_q && (pc == bp_addr_q);
    cpu_ce    = ((state_q == ST_RUN) && !bp_match) || (state_q == ST_STEP);
    halted    = (state_q == ST_HALT);
    bp_hit    = bp_hit_q;
    state_o   = state_q;
  end

`ifdef RUN_CTRL_CYCLE_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q + 32'(cpu_ce);
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) cycle_cnt_q <= 32'h0;
    else           cycle_cnt_q <= cycle_cnt_d;
  end

  assign cycle_cnt = cycle_cnt_q;
`else
  assign cycle_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed scenarios plus random commands vs a behavioural model.
module tb_cpu_run_ctrl;

  localparam logic [1:0] OP_HALT  = 2'b00;
  localparam logic [1:0] OP_RUN   = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;
  localparam logic [1:0] OP_SETBP = 2'b11;
  localparam int M_HALT = 0;
  localparam int M_RUN  = 1;
  localparam int M_STEP = 2;

  logic        cpu_clk   = 1'b0;
  logic        cpu_rstn  = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op    = 2'b00;
  logic [31:0] cmd_arg   = 32'h0;
  logic [31:0] pc        = 32'h0;
  logic        cmd_ready, cpu_ce, halted, bp_hit;
  logic [1:0]  state_o;
  logic [31:0] cycle_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_run_ctrl dut (
    .cpu_clk  (cpu_clk),
    .cpu_rstn (cpu_rstn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_arg  (cmd_arg),
    .pc       (pc),
    .cpu_ce   (cpu_ce),
    .halted   (halted),
    .bp_hit   (bp_hit),
    .state_o  (state_o),
    .cycle_cnt(cycle_cnt)
  );

  always #5 cpu_clk = ~cpu_clk;

  wire [37:0] obs = {cpu_ce, cmd_ready, halted, bp_hit, state_o, cycle_cnt};

  // Behavioural model: mode as an integer, breakpoint as (on, addr), step budget as a plain count.
  int          m_mode;
  bit          m_bp_on;
  logic [31:0] m_bp_addr;
  bit          m_resume_armed;
  int          m_steps_left;
  bit          m_hit;
  logic [31:0] m_cycles;
  bit          m_match, m_ce;
  logic [37:0] exp_v;

  task automatic model_reset();
    m_mode = M_HALT; m_bp_on = 0; m_bp_addr = 32'h0; m_resume_armed = 0;
    m_steps_left = 0; m_hit = 0; m_cycles = 32'h0;
  endtask

  task automatic model_eval();
    logic [1:0]  mode_bits;
    logic [31:0] exp_cnt;
    m_match = m_bp_on && (m_mode == M_RUN) && !m_resume_armed && (pc == m_bp_addr);
    m_ce = (m_mode == M_STEP) || ((m_mode == M_RUN) && !m_match);
    mode_bits = 2'(m_mode);
`ifdef RUN_CTRL_CYCLE_CNT_EN
    exp_cnt = m_cycles;
`else
    exp_cnt = 32'h0;
`endif
    exp_v = {m_ce, (m_mode != M_STEP), (m_mode == M_HALT), m_hit, mode_bits, exp_cnt};
  endtask

  task automatic model_edge();
    bit acc;
    model_eval();
    acc = cmd_valid && (m_mode != M_STEP);
    if (pc != m_bp_addr) m_resume_armed = 0;
    if (m_ce) m_cycles = m_cycles + 32'd1;
    if (acc) begin
      case (cmd_op)
        OP_HALT: begin
          if (m_match) m_hit = 1;
          m_mode = M_HALT;
        end
        OP_RUN: if (m_mode == M_HALT) begin
          m_mode = M_RUN; m_resume_armed = 1; m_hit = 0;
        end
        OP_STEP: begin
          m_steps_left = int'(cmd_arg % 32'd65536);
          if (m_steps_left == 0) m_steps_left = 1;
          m_mode = M_STEP; m_hit = 0;
        end
        default: begin
          m_bp_on   = (cmd_arg % 2) == 0;
          m_bp_addr = cmd_arg - (cmd_arg % 4);
        end
      endcase
    end else if (m_mode == M_STEP) begin
      m_steps_left = m_steps_left - 1;
      if (m_steps_left == 0) m_mode = M_HALT;
    end else if (m_match) begin
      m_mode = M_HALT; m_hit = 1;
    end
  endtask

  // Called 1 time unit after a rising edge; returns at the falling edge with expectations ready.
  task automatic apply(input bit v, input logic [1:0] op, input logic [31:0] arg, input logic [31:0] p);
    cmd_valid = v; cmd_op = op; cmd_arg = arg; pc = p;
    #4;
    model_eval();
  endtask

  task automatic clk_edge();
    model_edge();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic test_reset();
    cpu_rstn = 1'b0;
    model_reset();
    @(posedge cpu_clk); #1;
    apply(0, OP_HALT, 32'h0, 32'h0);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL reset_hold: got %h want %h", obs, exp_v); end
    cpu_rstn = 1'b1;
    clk_edge();
    for (int i = 0; i < 10; i++) begin
      apply(0, OP_HALT, 32'h0, 32'h40);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL reset_idle[%0d]: got %h want %h", i, obs, exp_v); end
      clk_edge();
    end
    n_checks++;
    if (cycle_cnt !== 32'h0 || halted !== 1'b1) begin
      n_fail++; $display("FAIL reset_end: cnt=%h halted=%b want 0/1", cycle_cnt, halted);
    end
  endtask

  task automatic test_step();
    logic [31:0] args [3] = '{32'd3, 32'd0, 32'h0001_0000};
    int          lens [3] = '{3, 1, 1};
    for (int t = 0; t < 3; t++) begin
      int ce_seen = 0;
      apply(1, OP_STEP, args[t], 32'h0);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL step_accept[%0d]: got %h want %h", t, obs, exp_v); end
      clk_edge();
      for (int i = 0; i < 5; i++) begin
        apply(0, OP_HALT, 32'h0, 32'h0);
        n_checks++;
        if (obs !== exp_v) begin n_fail++; $display("FAIL step_seq[%0d.%0d]: got %h want %h", t, i, obs, exp_v); end
        if (cpu_ce === 1'b1) ce_seen++;
        clk_edge();
      end
      n_checks++;
      if (ce_seen != lens[t] || halted !== 1'b1) begin
        n_fail++; $display("FAIL step_len[%0d]: ce_cycles=%0d halted=%b want %0d/1", t, ce_seen, halted, lens[t]);
      end
    end
  endtask

  task automatic test_breakpoint();
    logic [31:0] pc_r = 32'h0;
    apply(1, OP_SETBP, 32'h10, pc_r); clk_edge();
    apply(1, OP_RUN, 32'h0, pc_r);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL bp_run_accept: got %h want %h", obs, exp_v); end
    clk_edge();
    for (int i = 0; i < 12 && halted !== 1'b1; i++) begin
      apply(0, OP_HALT, 32'h0, pc_r);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL bp_run[%0d] pc=%h: got %h want %h", i, pc_r, obs, exp_v); end
      if (m_ce) pc_r = pc_r + 32'd4;
      clk_edge();
    end
    n_checks++;
    if (halted !== 1'b1 || bp_hit !== 1'b1 || pc_r !== 32'h10) begin
      n_fail++; $display("FAIL bp_stop: halted=%b hit=%b pc=%h want 1/1/10", halted, bp_hit, pc_r);
    end
  endtask

  task automatic test_resume();
    logic [31:0] seq [6] = '{32'h10, 32'h10, 32'h14, 32'h18, 32'h10, 32'h10};
    apply(1, OP_RUN, 32'h0, 32'h10); clk_edge();
    for (int i = 0; i < 6; i++) begin
      apply(0, OP_HALT, 32'h0, seq[i]);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL resume[%0d] pc=%h: got %h want %h", i, seq[i], obs, exp_v); end
      if (i < 2) begin
        n_checks++;
        if (cpu_ce !== 1'b1) begin n_fail++; $display("FAIL resume_stall[%0d]: ce=%b want 1", i, cpu_ce); end
      end
      clk_edge();
    end
    n_checks++;
    if (halted !== 1'b1 || bp_hit !== 1'b1) begin
      n_fail++; $display("FAIL resume_rehit: halted=%b hit=%b want 1/1", halted, bp_hit);
    end
  endtask

  task automatic test_disable();
    logic [31:0] pc_r = 32'h8;
    apply(1, OP_SETBP, 32'h11, pc_r); clk_edge();
    apply(1, OP_RUN, 32'h0, pc_r); clk_edge();
    for (int i = 0; i < 6; i++) begin
      apply(0, OP_HALT, 32'h0, pc_r);
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL bp_off_run[%0d] pc=%h: got %h want %h", i, pc_r, obs, exp_v); end
      if (m_ce) pc_r = pc_r + 32'd4;
      clk_edge();
    end
    n_checks++;
    if (halted !== 1'b0) begin n_fail++; $display("FAIL bp_off_nohalt: halted=%b want 0", halted); end
    apply(1, OP_HALT, 32'h0, pc_r); clk_edge();
    apply(0, OP_HALT, 32'h0, pc_r);
    n_checks++;
    if (obs !== exp_v || cpu_ce !== 1'b0 || bp_hit !== 1'b0) begin
      n_fail++; $display("FAIL halt_cmd: got %h want %h", obs, exp_v);
    end
    clk_edge();
  endtask

  task automatic test_async_reset();
    apply(1, OP_SETBP, 32'h100, 32'h40); clk_edge();
    apply(1, OP_RUN, 32'h0, 32'h40); clk_edge();
    apply(0, OP_HALT, 32'h0, 32'h44);
    n_checks++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL pre_reset_run: got %h want %h", obs, exp_v); end
    #1 cpu_rstn = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (cpu_ce !== 1'b0 || halted !== 1'b1 || bp_hit !== 1'b0 || cycle_cnt !== 32'h0) begin
      n_fail++; $display("FAIL async_reset: ce=%b halted=%b hit=%b cnt=%h want 0/1/0/0", cpu_ce, halted, bp_hit, cycle_cnt);
    end
    @(posedge cpu_clk); #1;
    cpu_rstn = 1'b1;
    apply(1, OP_RUN, 32'h0, 32'h0); clk_edge();
    for (int i = 0; i < 3; i++) begin
      apply(0, OP_HALT, 32'h0, (i == 0) ? 32'h0 : 32'h100);
      n_checks++;
      if (obs !== exp_v || cpu_ce !== 1'b1) begin
        n_fail++; $display("FAIL bp_cleared[%0d]: got %h want %h", i, obs, exp_v);
      end
      clk_edge();
    end
    apply(1, OP_HALT, 32'h0, 32'h100); clk_edge();
  endtask

  task automatic test_random();
    bit          pend = 0;
    logic [1:0]  op   = OP_HALT;
    logic [31:0] arg  = 32'h0;
    logic [31:0] pc_r = 32'h0;
    for (int i = 0; i < 400; i++) begin
      if (!pend && $urandom_range(0, 2) == 0) begin
        int w = $urandom_range(0, 9);
        pend = 1;
        if (w < 2)      begin op = OP_HALT;  arg = $urandom; end
        else if (w < 5) begin op = OP_RUN;   arg = $urandom; end
        else if (w < 7) begin op = OP_STEP;  arg = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 5)); end
        else            begin op = OP_SETBP; arg = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 1)); end
      end
      apply(pend, op, arg, pc_r);
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL random[%0d] op=%0d pc=%h: got %h want %h", i, op, pc_r, obs, exp_v);
      end
      if (pend && m_mode != M_STEP) pend = 0;
      if (m_ce && $urandom_range(0, 3) != 0) pc_r = (pc_r + 32'd4) & 32'h3C;
      else if ($urandom_range(0, 7) == 0) pc_r = 32'($urandom_range(0, 15) * 4);
      clk_edge();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    test_reset();
    test_step();
    test_breakpoint();
    test_resume();
    test_disable();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
